// File: rtl/com_bus_pkg.sv
// Shared types and helpers for the common-bus scheduler and its round-robin picker.
package com_bus_pkg;

  localparam int N_CORES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN      = 2'd1,
    ST_INV_WAIT = 2'd2
  } bus_st_e;

  // Owner index width; a single-core bus still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/com_bus_scheduler_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_pick
  import com_bus_pkg::*;
#(
  parameter  int N  = N_CORES_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] sel;

  always_comb begin
    for (int j = 0; j < N; j++) hi_mask[j] = (IW'(j) >= ptr);
    // Requests at/above the pointer win; otherwise wrap to the lowest one.
    sel = (|(req & hi_mask)) ? (req & hi_mask) : req;
    gnt = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (sel[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
      end
    end
    vld = |req;
  end

endmodule

// File: rtl/com_bus_scheduler.sv
// Common-bus scheduler: round-robin processor tenures, snoop/memory sub-grants,
// invalidation ack aggregation, Shared aggregation and a sticky hold watchdog.
module com_bus_scheduler
  import com_bus_pkg::*;
#(
  parameter  int N_CORES  = N_CORES_DEF,
  parameter  int MAX_HOLD = 255,
  parameter  int CNT_W    = 8,
  localparam int IW       = idx_w(N_CORES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CORES-1:0] Com_Bus_Req_proc,
  output logic [N_CORES-1:0] Com_Bus_Gnt_proc,
  input  logic [N_CORES-1:0] Com_Bus_Req_snoop,
  output logic [N_CORES-1:0] Com_Bus_Gnt_snoop,
  input  logic               Mem_snoop_req,
  output logic               Mem_snoop_gnt,
  input  logic               Invalidate,
  input  logic [N_CORES-1:0] Invalidation_done,
  output logic               All_Invalidation_done,
  input  logic [N_CORES-1:0] Shared_local,
  output logic               Shared,
  output logic [IW-1:0]      owner_id,
  output logic               bus_busy,
  output logic               hold_timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_CORES - 1);

  bus_st_e            state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_idx;
  logic [N_CORES-1:0] gnt_proc_q, gnt_proc_d, gnt_snoop_q, gnt_snoop_d;
  logic [N_CORES-1:0] inv_mask_q, inv_mask_d, mask_nxt;
  logic [N_CORES-1:0] pick_oh, snp_oh;
  logic               pick_vld, snp_vld, own_req;
  logic               mem_gnt_q, mem_gnt_d, all_inv_q, all_inv_d;
  logic               shared_q, shared_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  rr_pick #(.N(N_CORES)) u_proc_pick (
    .req(Com_Bus_Req_proc), .ptr(rr_ptr_q), .gnt(pick_oh), .vld(pick_vld)
  );

  // Fixed-priority snoop pick (pointer pinned at 0); the owner's own snoop port is masked.
  rr_pick #(.N(N_CORES)) u_snoop_pick (
    .req(Com_Bus_Req_snoop & ~gnt_proc_q), .ptr('0), .gnt(snp_oh), .vld(snp_vld)
  );

  assign own_req = |(Com_Bus_Req_proc & gnt_proc_q);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    mem_gnt_d   = mem_gnt_q;
    inv_mask_d  = inv_mask_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    all_inv_d   = 1'b0;
    mask_nxt    = inv_mask_q | (Invalidation_done & ~gnt_proc_q);
    pick_idx    = '0;
    for (int j = 0; j < N_CORES; j++) if (pick_oh[j]) pick_idx = IW'(j);

    if (state_q != ST_IDLE) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (cnt_d >= HOLD_LIM) timeout_d = 1'b1;
      // A new sub-grant is only considered when none is active, which leaves one gap cycle.
      if (|gnt_snoop_q) begin
        if (!(|(Com_Bus_Req_snoop & gnt_snoop_q))) gnt_snoop_d = '0;
      end else if (mem_gnt_q) begin
        if (!Mem_snoop_req) mem_gnt_d = 1'b0;
      end else if (snp_vld) begin
        gnt_snoop_d = snp_oh;
      end else if (Mem_snoop_req && state_q == ST_OWN) begin
        mem_gnt_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d    = ST_OWN;
          gnt_proc_d = pick_oh;
          owner_d    = pick_idx;
          cnt_d      = '0;
        end
      end
      ST_OWN: begin
        if (own_req && Invalidate) state_d = ST_INV_WAIT;
      end
      ST_INV_WAIT: begin
        if (!Invalidate) begin
          inv_mask_d = '0;
          state_d    = ST_OWN;
        end else if (&(mask_nxt | gnt_proc_q)) begin
          all_inv_d  = 1'b1;
          inv_mask_d = '0;
          state_d    = ST_OWN;
        end else begin
          inv_mask_d = mask_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !own_req) begin
      state_d     = ST_IDLE;
      gnt_proc_d  = '0;
      gnt_snoop_d = '0;
      mem_gnt_d   = 1'b0;
      inv_mask_d  = '0;
      all_inv_d   = 1'b0;
      rr_ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end

    shared_d = (state_d != ST_IDLE) && (|(Shared_local & ~gnt_proc_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      mem_gnt_q   <= 1'b0;
      inv_mask_q  <= '0;
      all_inv_q   <= 1'b0;
      shared_q    <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      mem_gnt_q   <= mem_gnt_d;
      inv_mask_q  <= inv_mask_d;
      all_inv_q   <= all_inv_d;
      shared_q    <= shared_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign Com_Bus_Gnt_proc      = gnt_proc_q;
  assign Com_Bus_Gnt_snoop     = gnt_snoop_q;
  assign Mem_snoop_gnt         = mem_gnt_q;
  assign All_Invalidation_done = all_inv_q;
  assign Shared                = shared_q;
  assign owner_id              = owner_q;
  assign bus_busy              = (state_q != ST_IDLE);
  assign hold_timeout          = timeout_q;

endmodule

// File: tb/tb_com_bus_scheduler.sv
// Directed bench for com_bus_scheduler (4 cores, MAX_HOLD=255).
module tb_com_bus_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_proc, gnt_proc, req_snoop, gnt_snoop, inv_done, shared_local;
  logic       mem_req, mem_gnt, invalidate, all_inv, shared, bus_busy, hold_timeout;
  logic [1:0] owner_id;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  com_bus_scheduler #(.N_CORES(4), .MAX_HOLD(255), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc(req_proc), .Com_Bus_Gnt_proc(gnt_proc),
    .Com_Bus_Req_snoop(req_snoop), .Com_Bus_Gnt_snoop(gnt_snoop),
    .Mem_snoop_req(mem_req), .Mem_snoop_gnt(mem_gnt),
    .Invalidate(invalidate), .Invalidation_done(inv_done),
    .All_Invalidation_done(all_inv), .Shared_local(shared_local), .Shared(shared),
    .owner_id(owner_id), .bus_busy(bus_busy), .hold_timeout(hold_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gproc"}, 32'(gnt_proc), 0);
    chk({tag, "_gsnp"},  32'(gnt_snoop), 0);
    chk({tag, "_misc"},  {25'd0, mem_gnt, all_inv, shared, owner_id, bus_busy, hold_timeout}, 0);
  endtask

  int         ord [5] = '{0, 1, 2, 3, 0};
  logic [3:0] e;

  initial begin
    rst_n = 1'b0; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
    invalidate = 1'b0; inv_done = '0; shared_local = '0;
    step(2);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic round robin from pointer 0.
    req_proc = 4'b1010; step(1);
    chk("t1_gnt1", 32'(gnt_proc), 32'h2);
    chk("t1_own1", 32'(owner_id), 1);
    chk("t1_busy", 32'(bus_busy), 1);
    req_proc = 4'b1000; step(1);
    chk("t1_idle", {gnt_proc, 3'd0, bus_busy}, 0);
    step(1);
    chk("t1_gnt3", 32'(gnt_proc), 32'h8);
    chk("t1_own3", 32'(owner_id), 3);
    req_proc = '0; step(1);

    // All four requesting: rotation with an idle cycle between tenures.
    req_proc = 4'b1111; step(1);
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << ord[k];
      chk("rr_gnt", 32'(gnt_proc), 32'(e));
      chk("rr_own", 32'(owner_id), 32'(ord[k]));
      step(4);
      chk("rr_hold", 32'(gnt_proc), 32'(e));
      req_proc = 4'b1111 & ~e; step(1);
      chk("rr_gap", {gnt_proc, 3'd0, bus_busy}, 0);
      req_proc = 4'b1111; step(1);
    end
    req_proc = '0; step(1);

    // Invalidation aggregation with owner 0.
    req_proc = 4'b0001; step(1);
    chk("inv_own0", 32'(owner_id), 0);
    invalidate = 1'b1; step(1);
    inv_done = 4'b0101; step(1);
    chk("inv_c2", 32'(all_inv), 0);
    inv_done = 4'b0011; step(1);
    chk("inv_c1", 32'(all_inv), 0);
    inv_done = 4'b1000; step(1);
    chk("inv_pulse", 32'(all_inv), 1);
    inv_done = 4'b0000; step(1);
    chk("inv_1cyc", 32'(all_inv), 0);
    inv_done = 4'b0111; step(1);
    invalidate = 1'b0; inv_done = '0; step(1);
    chk("inv_abort", 32'(all_inv), 0);
    invalidate = 1'b1; step(1);
    inv_done = 4'b1000; step(1);
    chk("inv_mask_clr", 32'(all_inv), 0);
    invalidate = 1'b0; inv_done = '0; step(1);
    shared_local = 4'b0001; step(1);
    chk("shr_owner", 32'(shared), 0);
    shared_local = 4'b0100; step(1);
    chk("shr_other", 32'(shared), 1);
    req_proc = '0; step(1);
    chk("shr_idle", 32'(shared), 0);
    shared_local = '0;

    // Snoop vs memory arbitration with owner 1.
    req_proc = 4'b0010; step(1);
    chk("snp_own1", 32'(owner_id), 1);
    req_snoop = 4'b0110; mem_req = 1'b1; step(1);
    chk("snp_gnt2", 32'(gnt_snoop), 32'h4);
    chk("snp_nomem", 32'(mem_gnt), 0);
    step(2);
    chk("snp_hold", {gnt_snoop, 3'd0, mem_gnt}, 32'h40);
    req_snoop = 4'b0010; step(1);
    chk("snp_gap", {gnt_snoop, 3'd0, mem_gnt}, 0);
    step(1);
    chk("mem_gnt", {gnt_snoop, 3'd0, mem_gnt}, 1);
    step(1);
    chk("mem_hold", 32'(mem_gnt), 1);
    mem_req = 1'b0; step(1);
    chk("mem_drop", 32'(mem_gnt), 0);
    mem_req = 1'b1; step(1);
    chk("mem_regnt", 32'(mem_gnt), 1);
    req_proc = '0; step(1);
    chk("eot_drop", {gnt_proc, gnt_snoop, 3'd0, mem_gnt}, 0);
    mem_req = 1'b0; req_snoop = '0;

    // Watchdog with owner 2.
    req_proc = 4'b0100; step(1);
    chk("wd_own2", 32'(owner_id), 2);
    step(254);
    chk("wd_254", 32'(hold_timeout), 0);
    step(1);
    chk("wd_255", 32'(hold_timeout), 1);
    chk("wd_held", 32'(gnt_proc), 32'h4);
    step(45);
    req_proc = '0; step(1);
    chk("wd_rel", {gnt_proc, 3'd0, hold_timeout}, 1);

    // Asynchronous reset in the middle of INV_WAIT.
    req_proc = 4'b1000; step(1);
    chk("ar_own3", 32'(owner_id), 3);
    invalidate = 1'b1; req_snoop = 4'b0001; shared_local = 4'b0001; step(1);
    chk("ar_pre", {gnt_snoop, 3'd0, shared}, 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("ar_async");
    req_proc = 4'b1111; invalidate = 1'b0; req_snoop = '0; shared_local = '0;
    step(1);
    rst_n = 1'b1; step(1);
    chk("ar_first", 32'(gnt_proc), 32'h1);
    chk("ar_own0", 32'(owner_id), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
